tetron_arbiter: RTL and testbench

- Downstream partner of the volatile cell store. Owns the static playfield and answers every movement request with one of three outcomes:
  - commit: move accepted;
  - decline: move rejected, store restores its previous position;
  - steal: a natural fall collided, so the piece is locked into the field.
- Also provides a read port for the renderer and a game-over flag.

---
 rtl/tetron_arbiter.sv | 271 +++++++++++++++++++++++++++
 tb/tb_tetron_arbiter.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/tetron_arbiter.sv
// Movement arbiter and static playfield: verifies proposed piece cells, answers commit/decline/steal.
// Optional row clearing is built only when LINE_CLEAR_EN is defined.
module tetron_arbiter #(
  parameter int unsigned ROWS = 20,
  parameter int unsigned COLS = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        movement_request,
  input  logic        movement_intent,
  input  logic [4:0]  blk1_v,
  input  logic [4:0]  blk2_v,
  input  logic [4:0]  blk3_v,
  input  logic [4:0]  blk4_v,
  input  logic [4:0]  blk1_h,
  input  logic [4:0]  blk2_h,
  input  logic [4:0]  blk3_h,
  input  logic [4:0]  blk4_h,
  input  logic [2:0]  piece_color,
  output logic        movement_commit,
  output logic        movement_declined,
  output logic        movement_steal,
  input  logic [4:0]  rd_v,
  input  logic [4:0]  rd_h,
  output logic [2:0]  rd_color,
  output logic        game_over,
  output logic [15:0] lines_cleared
);

  localparam int unsigned HW = $clog2(ROWS);
  localparam int unsigned VW = $clog2(COLS);
  localparam logic [4:0] RowsL = 5'(ROWS);
  localparam logic [4:0] ColsL = 5'(COLS);

  localparam logic [2:0] StIdle      = 3'd0;
  localparam logic [2:0] StCheck     = 3'd1;
  localparam logic [2:0] StResolve   = 3'd2;
  localparam logic [2:0] StHoldDecl  = 3'd3;
  localparam logic [2:0] StLock      = 3'd4;
  localparam logic [2:0] StClear     = 3'd5;
  localparam logic [2:0] StHoldSteal = 3'd6;
  localparam logic [2:0] StOver      = 3'd7;

  logic [2:0] state_q, state_d;
  logic [1:0] idx_q, idx_d;
  logic       hit_q, hit_d;
  logic       intent_q, intent_d;
  logic       lock_valid_q, lock_valid_d;
  logic [4:0] lock_h_q [4];
  logic [4:0] lock_h_d [4];
  logic [4:0] lock_v_q [4];
  logic [4:0] lock_v_d [4];
  logic [2:0] lock_color_q, lock_color_d;
  logic       declined_q, declined_d;
  logic       steal_q, steal_d;
  logic       game_over_q, game_over_d;
  logic [2:0] rd_color_q;
  logic [2:0] field_q [ROWS][COLS];
  logic [2:0] field_d [ROWS][COLS];
  logic       commit;

  logic [4:0] blk_h [4];
  logic [4:0] blk_v [4];
  logic [4:0] cur_h, cur_v, lk_h, lk_v;
  logic       cur_hit, lk_in_range;

  assign blk_h[0] = blk1_h;
  assign blk_h[1] = blk2_h;
  assign blk_h[2] = blk3_h;
  assign blk_h[3] = blk4_h;
  assign blk_v[0] = blk1_v;
  assign blk_v[1] = blk2_v;
  assign blk_v[2] = blk3_v;
  assign blk_v[3] = blk4_v;

  // A column of 0-1 wraps to 31 and so lands on the wall test.
  assign cur_h   = blk_h[idx_q];
  assign cur_v   = blk_v[idx_q];
  assign cur_hit = (cur_h >= RowsL || cur_v >= ColsL) ? 1'b1
                 : (field_q[cur_h[HW-1:0]][cur_v[VW-1:0]] != 3'd0);

  assign lk_h        = lock_h_q[idx_q];
  assign lk_v        = lock_v_q[idx_q];
  assign lk_in_range = (lk_h < RowsL) && (lk_v < ColsL);

`ifdef LINE_CLEAR_EN
  logic [4:0]  row_q, row_d, k_q, k_d, km1;
  logic        shift_q, shift_d, row_full;
  logic [15:0] lines_q, lines_d;

  assign km1 = k_q - 5'd1;

  always_comb begin
    row_full = 1'b1;
    for (int c = 0; c < COLS; c++) begin
      if (field_q[row_q[HW-1:0]][c] == 3'd0) row_full = 1'b0;
    end
  end
`endif

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    hit_d        = hit_q;
    intent_d     = intent_q;
    lock_valid_d = lock_valid_q;
    lock_h_d     = lock_h_q;
    lock_v_d     = lock_v_q;
    lock_color_d = lock_color_q;
    declined_d   = declined_q;
    steal_d      = steal_q;
    game_over_d  = game_over_q;
    field_d      = field_q;
    commit       = 1'b0;
`ifdef LINE_CLEAR_EN
    row_d        = row_q;
    k_d          = k_q;
    shift_d      = shift_q;
    lines_d      = lines_q;
`endif
    case (state_q)
      StIdle: begin
        if (movement_request) begin
          state_d  = StCheck;
          idx_d    = 2'd0;
          hit_d    = 1'b0;
          intent_d = movement_intent;
        end
      end
      StCheck: begin
        hit_d = hit_q | cur_hit;
        idx_d = idx_q + 2'd1;
        if (idx_q == 2'd3) state_d = StResolve;
      end
      StResolve: begin
        if (!hit_q) begin
          commit       = 1'b1;
          lock_h_d     = blk_h;
          lock_v_d     = blk_v;
          lock_color_d = piece_color;
          lock_valid_d = 1'b1;
          state_d      = StIdle;
        end else if (intent_q) begin
          declined_d = 1'b1;
          state_d    = StHoldDecl;
        end else if (lock_valid_q) begin
          steal_d = 1'b1;
          idx_d   = 2'd0;
          state_d = StLock;
        end else begin
          // Blocked right at spawn: the stack has reached the top.
          game_over_d = 1'b1;
          declined_d  = 1'b1;
          state_d     = StOver;
        end
      end
      StHoldDecl: begin
        if (!movement_request) begin
          declined_d = 1'b0;
          state_d    = StIdle;
        end
      end
      StLock: begin
        if (lk_in_range) field_d[lk_h[HW-1:0]][lk_v[VW-1:0]] = lock_color_q;
        idx_d = idx_q + 2'd1;
        if (idx_q == 2'd3) begin
`ifdef LINE_CLEAR_EN
          state_d = StClear;
          row_d   = RowsL - 5'd1;
          shift_d = 1'b0;
`else
          state_d = StHoldSteal;
`endif
        end
      end
`ifdef LINE_CLEAR_EN
      StClear: begin
        if (shift_q) begin
          if (k_q == 5'd0) begin
            for (int c = 0; c < COLS; c++) field_d[0][c] = 3'd0;
            lines_d = lines_q + 16'd1;
            shift_d = 1'b0;
          end else begin
            field_d[k_q[HW-1:0]] = field_q[km1[HW-1:0]];
            k_d = km1;
          end
        end else if (row_full) begin
          shift_d = 1'b1;
          k_d     = row_q;
        end else if (row_q == 5'd0) begin
          state_d = StHoldSteal;
        end else begin
          row_d = row_q - 5'd1;
        end
      end
`endif
      StHoldSteal: begin
        if (!movement_request) begin
          steal_d      = 1'b0;
          lock_valid_d = 1'b0;
          state_d      = StIdle;
        end
      end
      StOver: begin
        declined_d = movement_request;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= StIdle;
      idx_q        <= 2'd0;
      hit_q        <= 1'b0;
      intent_q     <= 1'b0;
      lock_valid_q <= 1'b0;
      lock_color_q <= 3'd0;
      declined_q   <= 1'b0;
      steal_q      <= 1'b0;
      game_over_q  <= 1'b0;
      rd_color_q   <= 3'd0;
      for (int i = 0; i < 4; i++) begin
        lock_h_q[i] <= 5'd0;
        lock_v_q[i] <= 5'd0;
      end
      for (int r = 0; r < ROWS; r++) begin
        for (int c = 0; c < COLS; c++) field_q[r][c] <= 3'd0;
      end
`ifdef LINE_CLEAR_EN
      row_q   <= 5'd0;
      k_q     <= 5'd0;
      shift_q <= 1'b0;
      lines_q <= 16'd0;
`endif
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      hit_q        <= hit_d;
      intent_q     <= intent_d;
      lock_valid_q <= lock_valid_d;
      lock_h_q     <= lock_h_d;
      lock_v_q     <= lock_v_d;
      lock_color_q <= lock_color_d;
      declined_q   <= declined_d;
      steal_q      <= steal_d;
      game_over_q  <= game_over_d;
      field_q      <= field_d;
      rd_color_q   <= (rd_h < RowsL && rd_v < ColsL) ? field_q[rd_h[HW-1:0]][rd_v[VW-1:0]]
                                                    : 3'd0;
`ifdef LINE_CLEAR_EN
      row_q   <= row_d;
      k_q     <= k_d;
      shift_q <= shift_d;
      lines_q <= lines_d;
`endif
    end
  end

  assign movement_commit   = commit;
  assign movement_declined = declined_q;
  assign movement_steal    = steal_q;
  assign rd_color          = rd_color_q;
  assign game_over         = game_over_q;
`ifdef LINE_CLEAR_EN
  assign lines_cleared = lines_q;
`else
  assign lines_cleared = 16'd0;
`endif

endmodule

// File: tb/tb_tetron_arbiter.sv
// Directed bench for tetron_arbiter: commit latency, declines, steal/lock, game over, reset abort.
module tb_tetron_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        movement_request, movement_intent;
  logic [4:0]  blk1_v, blk2_v, blk3_v, blk4_v;
  logic [4:0]  blk1_h, blk2_h, blk3_h, blk4_h;
  logic [2:0]  piece_color;
  logic        movement_commit, movement_declined, movement_steal;
  logic [4:0]  rd_v, rd_h;
  logic [2:0]  rd_color;
  logic        game_over;
  logic [15:0] lines_cleared;

  int n_checks = 0;
  int n_fail   = 0;
  int which, cyc;

  always #5 clk = ~clk;

  tetron_arbiter dut (
    .clk               (clk),
    .reset             (reset),
    .movement_request  (movement_request),
    .movement_intent   (movement_intent),
    .blk1_v            (blk1_v),
    .blk2_v            (blk2_v),
    .blk3_v            (blk3_v),
    .blk4_v            (blk4_v),
    .blk1_h            (blk1_h),
    .blk2_h            (blk2_h),
    .blk3_h            (blk3_h),
    .blk4_h            (blk4_h),
    .piece_color       (piece_color),
    .movement_commit   (movement_commit),
    .movement_declined (movement_declined),
    .movement_steal    (movement_steal),
    .rd_v              (rd_v),
    .rd_h              (rd_h),
    .rd_color          (rd_color),
    .game_over         (game_over),
    .lines_cleared     (lines_cleared)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_piece(input logic [4:0] h0, v0, h1, v1, h2, v2, h3, v3);
    blk1_h = h0; blk1_v = v0;
    blk2_h = h1; blk2_v = v1;
    blk3_h = h2; blk3_v = v2;
    blk4_h = h3; blk4_v = v3;
  endtask

  // Raise the request and wait for a verdict: 1 commit, 2 declined, 3 steal, 0 none.
  task automatic request(input logic intent, output int w, output int c);
    movement_intent  = intent;
    movement_request = 1'b1;
    w = 0;
    c = 0;
    for (int k = 1; k <= 20 && w == 0; k++) begin
      tick();
      if (movement_commit)        begin w = 1; c = k; end
      else if (movement_declined) begin w = 2; c = k; end
      else if (movement_steal)    begin w = 3; c = k; end
    end
  endtask

  task automatic wait_steal_drop(input string tag);
    for (int k = 0; k < 100 && movement_steal; k++) tick();
    check(tag, {31'd0, movement_steal}, 32'd0);
  endtask

  task automatic read_cell(input logic [4:0] h, input logic [4:0] v);
    rd_h = h;
    rd_v = v;
    tick();
  endtask

  // Commit the piece at the given cells, then force a blocked fall so it locks there.
  task automatic do_lock(input logic [4:0] h0, v0, h1, v1, h2, v2, h3, v3,
                         input logic [2:0] color);
    int w, c;
    piece_color = color;
    set_piece(h0, v0, h1, v1, h2, v2, h3, v3);
    request(1'b1, w, c);
    check("lock_commit", w, 1);
    movement_request = 1'b0;
    tick();
    blk1_h = 5'd20;
    request(1'b0, w, c);
    check("lock_steal", w, 3);
    movement_request = 1'b0;
    wait_steal_drop("lock_steal_drop");
  endtask

  initial begin
    reset = 1'b0;
    movement_request = 1'b0;
    movement_intent = 1'b0;
    piece_color = 3'd1;
    set_piece(5'd0, 5'd0, 5'd0, 5'd1, 5'd0, 5'd2, 5'd0, 5'd3);
    rd_h = 5'd0;
    rd_v = 5'd0;
    tick();
    tick();
    check("rst_commit", {31'd0, movement_commit}, 0);
    check("rst_declined", {31'd0, movement_declined}, 0);
    check("rst_steal", {31'd0, movement_steal}, 0);
    check("rst_game_over", {31'd0, game_over}, 0);
    check("rst_lines", {16'd0, lines_cleared}, 0);
    check("rst_rd", {29'd0, rd_color}, 0);
    reset = 1'b1;
    tick();

    // Free move: commit appears exactly in cycle 5.
    piece_color = 3'd5;
    set_piece(5'd5, 5'd5, 5'd5, 5'd6, 5'd5, 5'd7, 5'd5, 5'd8);
    request(1'b1, which, cyc);
    check("free_verdict", which, 1);
    check("free_latency", cyc, 5);
    movement_request = 1'b0;
    tick();
    check("free_commit_pulse", {31'd0, movement_commit}, 0);
    check("free_declined", {31'd0, movement_declined}, 0);
    check("free_steal", {31'd0, movement_steal}, 0);

    // Left-wall wrap: declined, held while request stays high.
    set_piece(5'd5, 5'd31, 5'd5, 5'd0, 5'd5, 5'd1, 5'd5, 5'd2);
    request(1'b1, which, cyc);
    check("wall_verdict", which, 2);
    check("wall_latency", cyc, 6);
    for (int k = 0; k < 3; k++) begin
      tick();
      check("wall_hold", {30'd0, movement_declined, movement_commit}, 32'd2);
    end
    movement_request = 1'b0;
    tick();
    check("wall_release", {31'd0, movement_declined}, 0);

    // Floor collision on natural fall locks the committed piece.
    piece_color = 3'd5;
    set_piece(5'd19, 5'd3, 5'd19, 5'd4, 5'd19, 5'd5, 5'd19, 5'd6);
    request(1'b1, which, cyc);
    check("floor_commit", which, 1);
    movement_request = 1'b0;
    tick();
    set_piece(5'd20, 5'd3, 5'd20, 5'd4, 5'd20, 5'd5, 5'd20, 5'd6);
    request(1'b0, which, cyc);
    check("floor_steal", which, 3);
    check("floor_steal_latency", cyc, 6);
    movement_request = 1'b0;
    wait_steal_drop("floor_steal_drop");
    read_cell(5'd19, 5'd3);
    check("floor_rd_19_3", {29'd0, rd_color}, 5);
    read_cell(5'd19, 5'd6);
    check("floor_rd_19_6", {29'd0, rd_color}, 5);
    read_cell(5'd18, 5'd3);
    check("floor_rd_18_3", {29'd0, rd_color}, 0);
    read_cell(5'd19, 5'd31);
    check("rd_out_of_range", {29'd0, rd_color}, 0);
    check("lines_no_clear", {16'd0, lines_cleared}, 0);

    // Reset while holding steal aborts to reset values.
    piece_color = 3'd3;
    set_piece(5'd18, 5'd3, 5'd17, 5'd3, 5'd16, 5'd3, 5'd15, 5'd3);
    request(1'b1, which, cyc);
    check("abort_commit", which, 1);
    movement_request = 1'b0;
    tick();
    set_piece(5'd19, 5'd3, 5'd18, 5'd3, 5'd17, 5'd3, 5'd16, 5'd3);
    request(1'b0, which, cyc);
    check("abort_steal", which, 3);
    for (int k = 0; k < 8; k++) tick();
    check("abort_steal_held", {31'd0, movement_steal}, 1);
    rd_h = 5'd19;
    rd_v = 5'd3;
    reset = 1'b0;
    movement_request = 1'b0;
    tick();
    check("abort_outputs",
          {12'd0, lines_cleared, game_over, movement_steal, movement_declined, movement_commit},
          0);
    check("abort_rd_reg", {29'd0, rd_color}, 0);
    reset = 1'b1;
    tick();
    check("abort_rd_19_3", {29'd0, rd_color}, 0);
    read_cell(5'd18, 5'd3);
    check("abort_rd_18_3", {29'd0, rd_color}, 0);

    // Blocked fall with no commit since spawn ends the game.
    do_lock(5'd6, 5'd5, 5'd6, 5'd6, 5'd6, 5'd7, 5'd6, 5'd8, 3'd4);
    set_piece(5'd6, 5'd5, 5'd6, 5'd6, 5'd6, 5'd7, 5'd6, 5'd8);
    request(1'b0, which, cyc);
    check("over_verdict", which, 2);
    check("over_flag", {31'd0, game_over}, 1);
    movement_request = 1'b0;
    tick();
    check("over_decl_drop", {31'd0, movement_declined}, 0);
    piece_color = 3'd7;
    set_piece(5'd0, 5'd0, 5'd0, 5'd1, 5'd0, 5'd2, 5'd0, 5'd3);
    request(1'b1, which, cyc);
    check("over_again_declined", which, 2);
    movement_request = 1'b0;
    tick();
    tick();
    check("over_sticky", {31'd0, game_over}, 1);
    read_cell(5'd0, 5'd0);
    check("over_frozen_0_0", {29'd0, rd_color}, 0);
    read_cell(5'd6, 5'd5);
    check("over_frozen_6_5", {29'd0, rd_color}, 4);

`ifdef LINE_CLEAR_EN
    reset = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    do_lock(5'd19, 5'd0, 5'd19, 5'd1, 5'd19, 5'd2, 5'd19, 5'd3, 3'd1);
    do_lock(5'd19, 5'd4, 5'd19, 5'd5, 5'd18, 5'd0, 5'd18, 5'd0, 3'd2);
    do_lock(5'd19, 5'd6, 5'd19, 5'd7, 5'd19, 5'd8, 5'd19, 5'd9, 3'd6);
    check("clear_lines", {16'd0, lines_cleared}, 1);
    read_cell(5'd19, 5'd0);
    check("clear_rd_19_0", {29'd0, rd_color}, 2);
    read_cell(5'd19, 5'd4);
    check("clear_rd_19_4", {29'd0, rd_color}, 0);
    for (int c = 0; c < 10; c++) begin
      read_cell(5'd18, 5'(c));
      check("clear_row18", {29'd0, rd_color}, 0);
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
